sram_fetch_arbiter: RTL and testbench
=====================================

# sram_fetch_arbiter

Arbitrates the single shared SRAM read port between the target fetcher (T) and the query fetcher (Q) inside `SmithWaterman`. Each requester issues a burst request (start address and length). The arbiter drives `select_T_o`/`addr_o` to the external memory and returns `data_i` to the owning requester one cycle later, tagged valid/last. Grants are round-robin, so neither the target stream nor the query stream starves.

## Interface
- `ADDR_BIT`, default 16: SRAM address width; must match `SRAM_ADDR_BIT`.
- `WORD_WIDTH`, default 32: SRAM word width; must match `SRAM_WORD_WIDTH`.
- `LEN_BIT`, default 4: burst-length field width; maximum burst is 2^LEN_BIT−1 words.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_t_i`  in  1  T requests a burst (level signal).
- `addr_t_i`  in  ADDR_BIT  T burst start address.
- `len_t_i`  in  LEN_BIT  T burst length in words.
- `gnt_t_o`  out  1  T request accepted this cycle.
- `valid_t_o`  out  1  `data_o` belongs to T.
- `last_t_o`  out  1  final word of the T burst.
- `req_q_i`, `addr_q_i`, `len_q_i`, `gnt_q_o`, `valid_q_o`, `last_q_o`: identical set for Q.
- `data_o`  out  WORD_WIDTH  returned word, shared by both requesters.
- `select_T_o`  out  1  1 = target memory, 0 = query memory.
- `addr_o`  out  ADDR_BIT  SRAM read address.
- `data_i`  in  WORD_WIDTH  SRAM read data; corresponds to the previous cycle's `addr_o`.
- `busy_o`  out  1  issue phase or return phase is in progress.

## Operation
- States:
  - IDLE: no burst issuing.
  - ISSUE_T: issuing T addresses.
  - ISSUE_Q: issuing Q addresses.
- Accept window: arbitration runs in IDLE, and also in the cycle that issues the final address of the current burst. This gives back-to-back bursts with no bubble.
- Arbitration:
  - One requester active in the window: grant it.
  - Both active: grant the one not served last. The `last_served` register resets to Q, so T wins the first tie.
- Grant signals:
  - `gnt_x_o` is combinational (Mealy) from `req_x_i`, state and `last_served`.
  - At most one grant is high per cycle.
  - The requester must deassert `req_x_i` the cycle after seeing `gnt_x_o`, unless it wants another burst.
- Accept cycle:
  - `addr_o` = `addr_x_i`; `select_T_o` = (x==T).
  - `len_x_i` and the address are captured; the remaining-count register is set to len−1.
  - `len_x_i` = 0 is treated as 1.
- Issue cycles: `addr_o` increments by 1 per cycle and wraps from 2^ADDR_BIT−1 to 0. The state returns to IDLE after the final address, unless a new accept occurs in that same cycle.
- Return pipeline: a 1-stage register holds {valid, owner, last} for each issued address. In the following cycle:
  - `data_o` = `data_i` (combinational pass-through);
  - `valid_x_o` asserts for the owner;
  - `last_x_o` asserts with the final word.
- Idle outputs: `select_T_o` and `addr_o` hold their last values. `valid_*`, `last_*` and `gnt_*` are 0.
- `busy_o` = (state≠IDLE) | return-stage valid.

## Timing
- Reset values (asynchronous): state IDLE, `addr_o` 0, `select_T_o` 0, `last_served` Q. All valid/last/return-stage bits 0, `busy_o` 0.
- Reset mid-burst: the in-flight burst is dropped and no valid or last is emitted after reset. Requesters must re-request.
- Burst of length L accepted in cycle N:
  - addresses appear in cycles N … N+L−1;
  - `valid_x_o` is high in cycles N+1 … N+L;
  - `last_x_o` is high in cycle N+L only.
- Back-to-back bursts: the second burst's first address appears in cycle N+L. Its first `valid` follows in cycle N+L+1, immediately after the previous `last`.
- Throughput: 1 word per cycle sustained.
- Maximum latency for a waiting requester: one full opposing burst (≤ 2^LEN_BIT−1 cycles).
- A requester that raises `req` in the final-issue cycle of its own burst, while the other side is also requesting, loses the tie.

## Test plan
- Single T burst, `addr_t_i`=0x0010, `len_t_i`=4, Q idle:
  - `gnt_t_o` pulses in cycle N;
  - `addr_o` = 0x10, 0x11, 0x12, 0x13 with `select_T_o`=1;
  - `valid_t_o` in cycles N+1..N+4 with `data_o` = mem[0x10..0x13];
  - `last_t_o` in cycle N+4; `busy_o` falls in cycle N+5.
- Simultaneous request, T len=2 at 0x00 and Q len=3 at 0x40, both held:
  - T is granted first (cycle N), Q is granted in cycle N+1;
  - `select_T_o` goes 1,1,0,0,0; Q data valid in cycles N+3..N+5.
- Both requesters request continuously with len=1, 8 bursts: grants alternate T,Q,T,Q…, 4 each, with no idle cycle.
- Wrap-around, Q len=3 at address 2^ADDR_BIT−2: `addr_o` = 0xFFFE, 0xFFFF, 0x0000 with `last_q_o` on the third word.
- `len_t_i`=0 at 0x20: exactly one word is returned, with `valid_t_o` and `last_t_o` high together.
- `rst_n` asserted mid-burst (T len=8, reset after the 3rd address):
  - all outputs are 0 immediately;
  - after release, no stray valid appears, `busy_o`=0;
  - the next tie goes to T.

Source files
------------

// File: rtl/sram_fetch_arbiter.sv
// Round-robin arbiter for the shared SRAM read port between the target (T) and query (Q) fetchers.
// Bursts are issued one address per cycle; read data is returned one cycle later, tagged with owner and last.
//
// state   | meaning
// IDLE    | no burst issuing; grants accepted and first address driven in the same cycle
// ISSUE_T | issuing T addresses; final-address cycle also accepts the next burst
// ISSUE_Q | issuing Q addresses; final-address cycle also accepts the next burst
module sram_fetch_arbiter #(
    parameter int ADDR_BIT   = 16,
    parameter int WORD_WIDTH = 32,
    parameter int LEN_BIT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_t_i,
    input  logic [ADDR_BIT-1:0]   addr_t_i,
    input  logic [LEN_BIT-1:0]    len_t_i,
    output logic                  gnt_t_o,
    output logic                  valid_t_o,
    output logic                  last_t_o,
    input  logic                  req_q_i,
    input  logic [ADDR_BIT-1:0]   addr_q_i,
    input  logic [LEN_BIT-1:0]    len_q_i,
    output logic                  gnt_q_o,
    output logic                  valid_q_o,
    output logic                  last_q_o,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  select_T_o,
    output logic [ADDR_BIT-1:0]   addr_o,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_T = 2'd1,
        ISSUE_Q = 2'd2
    } state_e;

    state_e              state_q;
    logic [ADDR_BIT-1:0] nxt_addr_q;
    logic [ADDR_BIT-1:0] hold_addr_q;
    logic                hold_sel_q;
    logic                t_served_last_q;
    logic [LEN_BIT-1:0]  rem_q;
    logic                ret_valid_q;
    logic                ret_t_q;
    logic                ret_last_q;

    logic                issuing;
    logic                final_issue;
    logic                window;
    logic                win_t;
    logic                win_q;
    logic                accept;
    logic                idle_accept;
    logic [ADDR_BIT-1:0] acc_addr;
    logic [LEN_BIT-1:0]  acc_len_raw;
    logic [LEN_BIT-1:0]  acc_len;
    logic                issue_now;
    logic                last_now;

    assign issuing     = (state_q != IDLE);
    assign final_issue = issuing && (rem_q == '0);
    assign window      = !issuing || final_issue;

    // Tie goes to whoever was not served last; a lone requester always wins.
    assign win_t = req_t_i && (!req_q_i || !t_served_last_q);
    assign win_q = req_q_i && !win_t;

    assign gnt_t_o = window && win_t;
    assign gnt_q_o = window && win_q;

    assign accept      = gnt_t_o || gnt_q_o;
    assign idle_accept = accept && !issuing;
    assign acc_addr    = gnt_t_o ? addr_t_i : addr_q_i;
    assign acc_len_raw = gnt_t_o ? len_t_i : len_q_i;
    assign acc_len     = (acc_len_raw == '0) ? LEN_BIT'(1) : acc_len_raw;

    // An accept from IDLE drives its first address immediately; an accept in the
    // final-issue cycle queues its burst behind the address already on the bus.
    always_comb begin
        addr_o     = hold_addr_q;
        select_T_o = hold_sel_q;
        if (idle_accept) begin
            addr_o     = acc_addr;
            select_T_o = gnt_t_o;
        end else if (issuing) begin
            addr_o     = nxt_addr_q;
            select_T_o = (state_q == ISSUE_T);
        end
    end

    assign issue_now = issuing || idle_accept;
    assign last_now  = issuing ? final_issue : (acc_len == LEN_BIT'(1));

    assign valid_t_o = ret_valid_q && ret_t_q;
    assign valid_q_o = ret_valid_q && !ret_t_q;
    assign last_t_o  = ret_valid_q && ret_t_q && ret_last_q;
    assign last_q_o  = ret_valid_q && !ret_t_q && ret_last_q;
    assign data_o    = ret_valid_q ? data_i : '0;
    assign busy_o    = issuing || ret_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            nxt_addr_q      <= '0;
            hold_addr_q     <= '0;
            hold_sel_q      <= 1'b0;
            t_served_last_q <= 1'b0;
            rem_q           <= '0;
            ret_valid_q     <= 1'b0;
            ret_t_q         <= 1'b0;
            ret_last_q      <= 1'b0;
        end else begin
            hold_addr_q <= addr_o;
            hold_sel_q  <= select_T_o;
            ret_valid_q <= issue_now;
            ret_t_q     <= select_T_o;
            ret_last_q  <= issue_now && last_now;

            if (accept) begin
                t_served_last_q <= gnt_t_o;
                if (issuing) begin
                    nxt_addr_q <= acc_addr;
                    rem_q      <= acc_len - LEN_BIT'(1);
                    state_q    <= gnt_t_o ? ISSUE_T : ISSUE_Q;
                end else begin
                    nxt_addr_q <= acc_addr + ADDR_BIT'(1);
                    rem_q      <= acc_len - LEN_BIT'(2);
                    if (acc_len > LEN_BIT'(1))
                        state_q <= gnt_t_o ? ISSUE_T : ISSUE_Q;
                    else
                        state_q <= IDLE;
                end
            end else if (issuing) begin
                nxt_addr_q <= nxt_addr_q + ADDR_BIT'(1);
                if (final_issue)
                    state_q <= IDLE;
                else
                    rem_q <= rem_q - LEN_BIT'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_fetch_arbiter.sv
// Scoreboard bench for sram_fetch_arbiter: grants expand into an expected address stream,
// which in turn expands into expected returned words one cycle later.
module tb_sram_fetch_arbiter;
    localparam int AB = 16;
    localparam int WW = 32;
    localparam int LB = 4;

    typedef struct packed {
        logic          sel;
        logic [AB-1:0] addr;
        logic          last;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_t_i = 1'b0, req_q_i = 1'b0;
    logic [AB-1:0] addr_t_i = '0, addr_q_i = '0;
    logic [LB-1:0] len_t_i = '0, len_q_i = '0;
    logic          gnt_t_o, gnt_q_o, valid_t_o, valid_q_o, last_t_o, last_q_o;
    logic [WW-1:0] data_o;
    logic          select_T_o;
    logic [AB-1:0] addr_o;
    logic [WW-1:0] data_i = '0;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    ent_t iss_q[$];
    ent_t ret_q[$];
    logic ls_t = 1'b0;
    logic gnt_seen_t = 1'b0, gnt_seen_q = 1'b0;
    int   n_gnt_t = 0, n_gnt_q = 0, n_issued = 0;
    logic [AB-1:0] smp_addr = '0;
    logic          smp_sel = 1'b0;

    sram_fetch_arbiter #(.ADDR_BIT(AB), .WORD_WIDTH(WW), .LEN_BIT(LB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_t_i(req_t_i), .addr_t_i(addr_t_i), .len_t_i(len_t_i),
        .gnt_t_o(gnt_t_o), .valid_t_o(valid_t_o), .last_t_o(last_t_o),
        .req_q_i(req_q_i), .addr_q_i(addr_q_i), .len_q_i(len_q_i),
        .gnt_q_o(gnt_q_o), .valid_q_o(valid_q_o), .last_q_o(last_q_o),
        .data_o(data_o), .select_T_o(select_T_o), .addr_o(addr_o),
        .data_i(data_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] memf(input logic sel, input logic [AB-1:0] a);
        return sel ? {a, ~a} : {~a ^ 16'h1111, a};
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // SRAM model: word for the address seen in the previous cycle.
    initial forever begin
        @(posedge clk);
        #1 data_i = memf(smp_sel, smp_addr);
    end

    // Monitor and reference model, evaluated mid-cycle once inputs have settled.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            iss_q.delete();
            ret_q.delete();
            ls_t       = 1'b0;
            gnt_seen_t = 1'b0;
            gnt_seen_q = 1'b0;
        end else begin
            automatic int   pre = iss_q.size();
            automatic logic had_ret = 1'b0;
            automatic logic et, eq;
            automatic ent_t e;
            if (ret_q.size() > 0) begin
                e = ret_q.pop_front();
                had_ret = 1'b1;
                check("valid_t", 64'(valid_t_o), 64'(e.sel));
                check("valid_q", 64'(valid_q_o), 64'(!e.sel));
                check("last_t", 64'(last_t_o), 64'(e.sel && e.last));
                check("last_q", 64'(last_q_o), 64'(!e.sel && e.last));
                check("data", 64'(data_o), 64'(memf(e.sel, e.addr)));
            end else begin
                check("idle_ret", 64'({valid_t_o, valid_q_o, last_t_o, last_q_o}), 64'(0));
            end
            check("busy", 64'(busy_o), 64'(pre > 0 || had_ret));
            check("gnt_excl", 64'(gnt_t_o && gnt_q_o), 64'(0));
            et = 1'b0;
            eq = 1'b0;
            if (pre <= 1) begin
                et = req_t_i && (!req_q_i || !ls_t);
                eq = req_q_i && !et;
            end
            check("gnt_t", 64'(gnt_t_o), 64'(et));
            check("gnt_q", 64'(gnt_q_o), 64'(eq));
            gnt_seen_t = gnt_t_o;
            gnt_seen_q = gnt_q_o;
            if (gnt_t_o || gnt_q_o) begin
                automatic logic          s = gnt_t_o;
                automatic logic [AB-1:0] a = s ? addr_t_i : addr_q_i;
                automatic logic [LB-1:0] l = s ? len_t_i : len_q_i;
                automatic int            n = (l == '0) ? 1 : int'(l);
                for (int i = 0; i < n; i++) begin
                    iss_q.push_back('{sel: s, addr: a, last: (i == n - 1)});
                    a = a + 16'd1;
                end
                ls_t = s;
                if (s) n_gnt_t++; else n_gnt_q++;
            end
            if (iss_q.size() > 0) begin
                e = iss_q.pop_front();
                check("addr_o", 64'(addr_o), 64'(e.addr));
                check("select", 64'(select_T_o), 64'(e.sel));
                ret_q.push_back(e);
                n_issued++;
            end
        end
        smp_addr = addr_o;
        smp_sel  = select_T_o;
    end

    task automatic pick(output logic [AB-1:0] a, output logic [LB-1:0] l);
        l = LB'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) a = 16'hFFFF - AB'($urandom_range(0, 3));
        else a = AB'($urandom);
    endtask

    task automatic serve(input int budget);
        for (int i = 0; i < budget && (req_t_i || req_q_i); i++) begin
            step();
            if (gnt_seen_t) req_t_i = 1'b0;
            if (gnt_seen_q) req_q_i = 1'b0;
        end
        check("serve_done", 64'(req_t_i || req_q_i), 64'(0));
        for (int i = 0; i < 40 && busy_o; i++) step();
        step();
        check("drained", 64'(busy_o), 64'(0));
    endtask

    initial begin
        int k;
        repeat (3) step();
        check("rst_outs", 64'({valid_t_o, valid_q_o, last_t_o, last_q_o, busy_o, select_T_o}), 64'(0));
        check("rst_addr", 64'(addr_o), 64'(0));
        rst_n = 1'b1;
        step();

        req_t_i = 1'b1; addr_t_i = 16'h0010; len_t_i = 4'd4;
        serve(20);

        req_t_i = 1'b1; addr_t_i = 16'h0000; len_t_i = 4'd2;
        req_q_i = 1'b1; addr_q_i = 16'h0040; len_q_i = 4'd3;
        serve(20);

        req_q_i = 1'b1; addr_q_i = 16'hFFFE; len_q_i = 4'd3;
        serve(20);

        req_t_i = 1'b1; addr_t_i = 16'h0020; len_t_i = 4'd0;
        serve(20);

        n_gnt_t = 0; n_gnt_q = 0; k = 0;
        req_t_i = 1'b1; addr_t_i = 16'h0100; len_t_i = 4'd1;
        req_q_i = 1'b1; addr_q_i = 16'h0200; len_q_i = 4'd1;
        while (n_gnt_t + n_gnt_q < 8 && k < 30) begin
            step();
            k++;
        end
        req_t_i = 1'b0; req_q_i = 1'b0;
        check("alt_cycles", 64'(k), 64'(8));
        check("alt_t", 64'(n_gnt_t), 64'(4));
        check("alt_q", 64'(n_gnt_q), 64'(4));
        serve(5);

        for (int c = 0; c < 3000; c++) begin
            step();
            if (!req_t_i || gnt_seen_t) begin
                if ($urandom_range(0, 2) != 0) begin
                    req_t_i = 1'b1; pick(addr_t_i, len_t_i);
                end else req_t_i = 1'b0;
            end
            if (!req_q_i || gnt_seen_q) begin
                if ($urandom_range(0, 2) != 0) begin
                    req_q_i = 1'b1; pick(addr_q_i, len_q_i);
                end else req_q_i = 1'b0;
            end
        end
        serve(40);
        check("iss_empty", 64'(iss_q.size()), 64'(0));
        check("ret_empty", 64'(ret_q.size()), 64'(0));

        req_t_i = 1'b1; addr_t_i = 16'h0300; len_t_i = 4'd8;
        k = n_issued;
        for (int i = 0; i < 20 && n_issued - k < 3; i++) begin
            step();
            if (gnt_seen_t) req_t_i = 1'b0;
        end
        check("rb_issued", 64'(n_issued - k), 64'(3));
        req_t_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rb_outs", 64'({gnt_t_o, gnt_q_o, valid_t_o, valid_q_o, last_t_o, last_q_o, busy_o, select_T_o}), 64'(0));
        check("rb_addr", 64'(addr_o), 64'(0));
        check("rb_data", 64'(data_o), 64'(0));
        repeat (2) step();
        rst_n = 1'b1;
        repeat (12) step();
        check("rb_busy", 64'(busy_o), 64'(0));
        req_t_i = 1'b1; addr_t_i = 16'h0030; len_t_i = 4'd1;
        req_q_i = 1'b1; addr_q_i = 16'h0031; len_q_i = 4'd1;
        step();
        check("rb_tie_t", 64'({gnt_seen_t, gnt_seen_q}), 64'(2'b10));
        serve(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
